// File: rtl/sw_debounce_pkg.sv
// Shared project constants for the switch front end and the downstream counter/LED stages.
package sw_debounce_pkg;
    localparam int DEF_NB_SW          = 4;
    localparam int DEF_NB_DEBOUNCE    = 16;
    localparam int DEF_DEBOUNCE_LIMIT = 50000;
    localparam int NB_COUNTER         = 8;
    localparam int NB_LEDS            = 4;
endpackage

// File: rtl/debounce_bit.sv
// One switch bit: two-flop synchronizer, stability counter, debounced level and edge pulses.
module debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int NB_DEBOUNCE    = DEF_NB_DEBOUNCE,
    parameter int DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_sw,
    output logic o_sw,
    output logic o_rise,
    output logic o_fall,
    output logic o_toggle_next
);
    localparam logic [NB_DEBOUNCE-1:0] CNT_LAST = NB_DEBOUNCE'(DEBOUNCE_LIMIT - 1);

    logic [1:0]             sync;
    logic [NB_DEBOUNCE-1:0] cnt;
    logic                   sync_q;
    logic                   differ;

    assign sync_q        = sync[1];
    assign differ        = sync_q != o_sw;
    // Exposed so the top can register o_change in the same cycle the level moves.
    assign o_toggle_next = differ && (cnt == CNT_LAST);

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            sync   <= 2'b00;
            cnt    <= '0;
            o_sw   <= 1'b0;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
        end else begin
            sync   <= {sync[0], i_sw};
            o_rise <= 1'b0;
            o_fall <= 1'b0;
            if (o_toggle_next) begin
                o_sw   <= sync_q;
                cnt    <= '0;
                o_rise <= sync_q;
                o_fall <= ~sync_q;
            end else if (differ) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/sw_debounce.sv
// Debounces NB_SW raw switches independently and reports per-bit edges plus a combined change pulse.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int NB_SW          = DEF_NB_SW,
    parameter int NB_DEBOUNCE    = DEF_NB_DEBOUNCE,
    parameter int DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic [NB_SW-1:0] i_sw,
    output logic [NB_SW-1:0] o_sw,
    output logic [NB_SW-1:0] o_rise,
    output logic [NB_SW-1:0] o_fall,
    output logic             o_change
);
    logic [NB_SW-1:0] toggle_next;

    for (genvar g = 0; g < NB_SW; g++) begin : g_bit
        debounce_bit #(
            .NB_DEBOUNCE    (NB_DEBOUNCE),
            .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT)
        ) u_bit (
            .clock         (clock),
            .i_reset       (i_reset),
            .i_sw          (i_sw[g]),
            .o_sw          (o_sw[g]),
            .o_rise        (o_rise[g]),
            .o_fall        (o_fall[g]),
            .o_toggle_next (toggle_next[g])
        );
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            o_change <= 1'b0;
        end else begin
            o_change <= |toggle_next;
        end
    end
endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce with a window-based reference model of the debounce rule.
module tb_sw_debounce;
    localparam int NSW   = 4;
    localparam int LIMIT = 4;
    localparam int MAXE  = 4096;

    logic           clock = 1'b0;
    logic           i_reset = 1'b1;
    logic [NSW-1:0] i_sw = '0;
    logic [NSW-1:0] o_sw, o_rise, o_fall;
    logic           o_change;

    sw_debounce #(.NB_SW(NSW), .NB_DEBOUNCE(3), .DEBOUNCE_LIMIT(LIMIT)) dut (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_sw     (i_sw),
        .o_sw     (o_sw),
        .o_rise   (o_rise),
        .o_fall   (o_fall),
        .o_change (o_change)
    );

    always #5 clock = ~clock;

    typedef struct {
        int             edge_n;
        logic [NSW-1:0] sw;
        logic [NSW-1:0] rise;
        logic [NSW-1:0] fall;
    } ev_t;

    ev_t            exp_q[$];
    int             checks = 0;
    int             errors = 0;
    int             edge_cnt = 0;
    int             last_change_edge = -1;
    int             n_changes = 0;
    logic [NSW-1:0] in_hist [0:MAXE-1];
    logic [NSW-1:0] lvl = '0;
    int             last_flip [NSW];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    // Model: a bit flips at edge n when the synchronized values seen after edges n-LIMIT..n-1
    // all disagree with the current level and that window lies entirely after the last flip.
    task automatic cycle(input logic [NSW-1:0] v);
        int n;
        logic [NSW-1:0] r, f;
        n = edge_cnt + 1;
        in_hist[n] = v;
        r = '0;
        f = '0;
        for (int b = 0; b < NSW; b++) begin
            if (n - LIMIT >= last_flip[b]) begin
                bit ok;
                ok = 1'b1;
                for (int j = n - LIMIT; j < n; j++) begin
                    logic sv;
                    sv = (j >= 2) ? in_hist[j-1][b] : 1'b0;
                    if (sv == lvl[b]) ok = 1'b0;
                end
                if (ok) begin
                    lvl[b]       = ~lvl[b];
                    last_flip[b] = n;
                    r[b]         = lvl[b];
                    f[b]         = ~lvl[b];
                end
            end
        end
        if ((r | f) != '0) exp_q.push_back('{n, lvl, r, f});
        i_sw = v;
        @(posedge clock);
        edge_cnt = n;
        #2;
    endtask

    task automatic hold(input logic [NSW-1:0] v, input int cycles);
        for (int i = 0; i < cycles; i++) cycle(v);
    endtask

    task automatic model_reset();
        edge_cnt = 0;
        lvl = '0;
        for (int b = 0; b < NSW; b++) last_flip[b] = 0;
    endtask

    always @(negedge clock) begin
        if (!i_reset) begin
            while (exp_q.size() > 0 && exp_q[0].edge_n < edge_cnt) begin
                checks++;
                errors++;
                $display("FAIL missed_event: no pulse seen, expected at edge %0d sw=%0h", exp_q[0].edge_n, exp_q[0].sw);
                void'(exp_q.pop_front());
            end
            if (o_change) begin
                n_changes++;
                last_change_edge = edge_cnt;
            end
            if (o_change || (o_rise != '0) || (o_fall != '0)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: rise=%0h fall=%0h change=%0b expected none", o_rise, o_fall, o_change);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("event_edge", edge_cnt, e.edge_n);
                    check("event_sw", o_sw, e.sw);
                    check("event_rise", o_rise, e.rise);
                    check("event_fall", o_fall, e.fall);
                    check("event_change", o_change, 1'b1);
                end
            end
        end
    end

    initial begin
        int n0, nc;
        model_reset();
        #13;
        check("reset_sw", o_sw, 0);
        check("reset_pulses", {o_rise, o_fall, o_change}, 0);
        @(posedge clock);
        #2;
        i_reset = 1'b0;
        model_reset();

        // Clean rise on bit 0 lands at edge 6.
        hold(4'b0001, 8);
        check("t1_change_edge", last_change_edge, 6);
        check("t1_sw", o_sw, 4'b0001);

        // Short glitch never reaches the output.
        hold(4'b0000, 8);
        nc = n_changes;
        hold(4'b0001, 3);
        hold(4'b0000, 8);
        check("t2_no_change", n_changes, nc);
        check("t2_sw", o_sw, 4'b0000);

        // Two bits together give one combined change.
        nc = n_changes;
        hold(4'b1010, 8);
        check("t3_single_change", n_changes, nc + 1);
        check("t3_sw", o_sw, 4'b1010);

        // Fall on bit 3.
        hold(4'b1000, 8);
        n0 = edge_cnt + 1;
        hold(4'b0000, 8);
        check("t4_fall_edge", last_change_edge, n0 + 5);
        check("t4_sw", o_sw, 4'b0000);

        // Async reset two cycles into a count, with o_sw already high.
        hold(4'b0001, 8);
        hold(4'b0011, 2);
        i_reset = 1'b1;
        #1;
        check("t5_async_sw", o_sw, 0);
        check("t5_async_pulses", {o_rise, o_fall, o_change}, 0);
        @(posedge clock);
        @(posedge clock);
        #2;
        check("t5_queue_empty", exp_q.size(), 0);
        exp_q.delete();
        nc = n_changes;
        i_reset = 1'b0;
        model_reset();
        cycle(4'b0011);
        check("t5_no_release_pulse", n_changes, nc);
        hold(4'b0011, 7);
        check("t5_restart_edge", last_change_edge, 6);
        check("t5_sw", o_sw, 4'b0011);

        // Bouncing input on bit 0: only the final 4-long run counts.
        hold(4'b0000, 8);
        n0 = edge_cnt + 1;
        cycle(4'b0001); cycle(4'b0000); cycle(4'b0001); cycle(4'b0001);
        cycle(4'b0000);
        hold(4'b0001, 8);
        check("t6_bounce_edge", last_change_edge, n0 + 10);
        check("t6_sw", o_sw, 4'b0001);

        // Randomized runs of varying length, biased toward short bounces.
        for (int i = 0; i < 400; i++) begin
            logic [NSW-1:0] v;
            v = NSW'($urandom);
            hold(v, $urandom_range(1, 7));
        end
        hold(4'b0110, 10);
        check("final_sw", o_sw, 4'b0110);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
